// File: rtl/pe_out_collector.sv
// Output collector for the PE datapath: packs PACK rounded results into one wide
// word and queues packed words in a small first-word-fall-through FIFO.
module pe_out_collector #(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int PACK           = 4,
  parameter int DEPTH          = 4,
  localparam int W     = para_int_bits + para_frac_bits,
  localparam int CNTW  = $clog2(PACK + 1),
  localparam int LVLW  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        in_data,
  input  logic                in_valid,
  input  logic                flush,
  output logic [PACK*W-1:0]   out_data,
  output logic [CNTW-1:0]     out_count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LVLW-1:0]     level,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int IDXW = $clog2(PACK);
  localparam int PW   = $clog2(DEPTH);

  // pack stage
  logic [IDXW-1:0]      r_idx;
  logic [W-1:0]         r_lane [PACK];
  logic [PACK*W-1:0]    w_word;
  logic [CNTW-1:0]      w_push_cnt;
  logic                 w_last;
  logic                 w_push;

  // fifo
  logic [PACK*W-1:0]    r_mem_data [DEPTH];
  logic [CNTW-1:0]      r_mem_cnt  [DEPTH];
  logic [PW:0]          r_wptr;
  logic [PW:0]          r_rptr;
  logic                 r_overflow;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;
  logic                 w_drop;

  assign w_last     = (r_idx == IDXW'(PACK - 1));
  assign w_push     = (in_valid && w_last) || (flush && (in_valid || (r_idx != '0)));
  assign w_push_cnt = in_valid ? (CNTW'(r_idx) + CNTW'(1)) : CNTW'(r_idx);

  // The word being pushed already contains the sample arriving this cycle.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < PACK; i++) begin
      w_word[i*W +: W] = (in_valid && (r_idx == IDXW'(i))) ? in_data : r_lane[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      for (int i = 0; i < PACK; i++) r_lane[i] <= '0;
    end else if (w_push) begin
      r_idx <= '0;
      for (int i = 0; i < PACK; i++) r_lane[i] <= '0;
    end else if (in_valid) begin
      r_lane[r_idx] <= in_data;
      r_idx         <= r_idx + IDXW'(1);
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop   = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_cnt[i]  <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem_data[r_wptr[PW-1:0]] <= w_word;
        r_mem_cnt[r_wptr[PW-1:0]]  <= w_push_cnt;
        r_wptr                     <= r_wptr + (PW+1)'(1);
      end
      if (w_pop) r_rptr <= r_rptr + (PW+1)'(1);
      if (w_drop) r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem_data[r_rptr[PW-1:0]];
  assign out_count = w_empty ? '0 : r_mem_cnt[r_rptr[PW-1:0]];
  assign level     = LVLW'(r_wptr - r_rptr);
  assign overflow  = r_overflow;

endmodule
